crtc_6845: RTL

- MC6845-compatible CRT controller for the Colour Genie video path.
- Generates the character-row/scanline timing that drives video memory fetch:
  - 14-bit refresh address (vma) and scanline address (ra);
  - hsync/vsync, display enable and cursor.
- Programmed by the Z80 through an address/data register pair on the I/O bus.
- Sits between the clock generator (character clock enable) and the memory/video fetch block, which consumes vma, ra[2:0] and hsync.

---
 rtl/crtc_6845.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/crtc_6845.sv
// MC6845-style CRT controller: character/scanline timing, refresh address, syncs, cursor.
// Latency: vma/ra/de/syncs update one clock after the cce that advances them; cursor lags by CURSOR_SKEW cces. No backpressure.
module crtc_6845 #(
    parameter int CURSOR_SKEW = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cce,
    input  logic        ce,
    input  logic        cs,
    input  logic        rs,
    input  logic        wr,
    input  logic [7:0]  d,
    output logic [7:0]  q,
    output logic [13:0] vma,
    output logic [4:0]  ra,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        cursor
);

    localparam logic [7:0] REG_MASK [16] = '{
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h1F, 8'h7F, 8'h7F,
        8'h03, 8'h1F, 8'h7F, 8'h1F, 8'h3F, 8'hFF, 8'h3F, 8'hFF
    };
    localparam logic [1:0] SKEW_SEL = 2'(CURSOR_SKEW);

    logic [7:0]  r_q [16];
    logic [7:0]  r_d [16];
    logic [4:0]  addr_q, addr_d;

    logic [7:0]  hc_q, hc_d;
    logic [6:0]  vc_q, vc_d;
    logic [4:0]  ra_cnt_q, ra_cnt_d;
    logic [13:0] row_start_q, row_start_d;
    logic        adj_q, adj_d;
    logic [4:0]  frame_q, frame_d;
    logic        hs_q, hs_d;
    logic [3:0]  hs_rem_q, hs_rem_d;
    logic        vs_q, vs_d;
    logic [4:0]  vs_rem_q, vs_rem_d;
    logic [13:0] vma_q, vma_d;
    logic [4:0]  ra_q, ra_d;
    logic        de_q, de_d;
    logic [2:0]  cur_q, cur_d;

    logic        line_end;
    logic        frame_end;
    logic        hde, vde;
    logic        vs_start;
    logic        blink_on;
    logic        cur_now;
    logic [13:0] fetch_addr;

    // CPU register file: address latch on rs=0, masked data write on rs=1
    always_comb begin
        r_d    = r_q;
        addr_d = addr_q;
        if (ce && cs && !wr) begin
            if (!rs) begin
                addr_d = d[4:0];
            end else if (!addr_q[4]) begin
                r_d[addr_q[3:0]] = d & REG_MASK[addr_q[3:0]];
            end
        end
    end

    always_comb begin
        q = 8'h00;
        if (rs && addr_q == 5'd14) begin
            q = r_q[14];
        end else if (rs && addr_q == 5'd15) begin
            q = r_q[15];
        end
    end

    assign line_end   = (hc_q == r_q[0]);
    assign hde        = (hc_q < r_q[1]);
    assign vde        = (vc_q < r_q[6][6:0]) && !adj_q;
    assign vs_start   = !adj_q && (ra_cnt_q == 5'd0) && (vc_q == r_q[7][6:0]);
    assign fetch_addr = row_start_q + 14'(hc_q);

    always_comb begin
        blink_on = 1'b1;
        case (r_q[10][6:5])
            2'b00:   blink_on = 1'b1;
            2'b01:   blink_on = 1'b0;
            2'b10:   blink_on = !frame_q[3];
            default: blink_on = !frame_q[4];
        endcase
    end

    assign cur_now = hde && vde && blink_on
                   && (fetch_addr == {r_q[14][5:0], r_q[15]})
                   && (r_q[10][4:0] <= ra_cnt_q) && (ra_cnt_q <= r_q[11][4:0]);

    always_comb begin
        hc_d        = hc_q;
        vc_d        = vc_q;
        ra_cnt_d    = ra_cnt_q;
        row_start_d = row_start_q;
        adj_d       = adj_q;
        frame_d     = frame_q;
        hs_d        = hs_q;
        hs_rem_d    = hs_rem_q;
        vs_d        = vs_q;
        vs_rem_d    = vs_rem_q;
        vma_d       = vma_q;
        ra_d        = ra_q;
        de_d        = de_q;
        cur_d       = cur_q;
        frame_end   = 1'b0;
        if (cce) begin
            hc_d = line_end ? 8'd0 : hc_q + 8'd1;

            // Width 0 wraps the remaining-count to 15, giving 16 cces
            if (hc_q == r_q[2]) begin
                hs_d     = 1'b1;
                hs_rem_d = r_q[3][3:0] - 4'd1;
            end else if (hs_q) begin
                if (hs_rem_q == 4'd0) begin
                    hs_d = 1'b0;
                end else begin
                    hs_rem_d = hs_rem_q - 4'd1;
                end
            end

            // Lines are counted at line end; vsync drops at the start of the following line
            if (line_end && vs_q && vs_rem_q != 5'd0) begin
                vs_rem_d = vs_rem_q - 5'd1;
            end
            if (hc_q == 8'd0) begin
                if (vs_start) begin
                    vs_d     = 1'b1;
                    vs_rem_d = (r_q[3][7:4] == 4'd0) ? 5'd16 : {1'b0, r_q[3][7:4]};
                end else if (vs_q && vs_rem_q == 5'd0) begin
                    vs_d = 1'b0;
                end
            end

            if (line_end) begin
                if (adj_q) begin
                    if (ra_cnt_q == r_q[5][4:0] - 5'd1) begin
                        frame_end = 1'b1;
                    end else begin
                        ra_cnt_d = ra_cnt_q + 5'd1;
                    end
                end else if (ra_cnt_q == r_q[9][4:0]) begin
                    ra_cnt_d    = 5'd0;
                    vc_d        = vc_q + 7'd1;
                    row_start_d = row_start_q + 14'(r_q[1]);
                    if (vc_q == r_q[4][6:0]) begin
                        if (r_q[5][4:0] != 5'd0) begin
                            adj_d = 1'b1;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end
                end else begin
                    ra_cnt_d = ra_cnt_q + 5'd1;
                end
            end

            if (frame_end) begin
                vc_d        = 7'd0;
                ra_cnt_d    = 5'd0;
                row_start_d = {r_q[12][5:0], r_q[13]};
                adj_d       = 1'b0;
                frame_d     = frame_q + 5'd1;
            end

            vma_d = fetch_addr;
            ra_d  = ra_cnt_q;
            de_d  = hde && vde;
            cur_d = {cur_q[1:0], cur_now};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_q[i] <= 8'h00;
            end
            addr_q      <= '0;
            hc_q        <= '0;
            vc_q        <= '0;
            ra_cnt_q    <= '0;
            row_start_q <= '0;
            adj_q       <= 1'b0;
            frame_q     <= '0;
            hs_q        <= 1'b0;
            hs_rem_q    <= '0;
            vs_q        <= 1'b0;
            vs_rem_q    <= '0;
            vma_q       <= '0;
            ra_q        <= '0;
            de_q        <= 1'b0;
            cur_q       <= '0;
        end else begin
            r_q         <= r_d;
            addr_q      <= addr_d;
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            ra_cnt_q    <= ra_cnt_d;
            row_start_q <= row_start_d;
            adj_q       <= adj_d;
            frame_q     <= frame_d;
            hs_q        <= hs_d;
            hs_rem_q    <= hs_rem_d;
            vs_q        <= vs_d;
            vs_rem_q    <= vs_rem_d;
            vma_q       <= vma_d;
            ra_q        <= ra_d;
            de_q        <= de_d;
            cur_q       <= cur_d;
        end
    end

    assign vma    = vma_q;
    assign ra     = ra_q;
    assign hsync  = hs_q;
    assign vsync  = vs_q;
    assign de     = de_q;
    assign cursor = cur_q[SKEW_SEL];

endmodule
